// File: rtl/sdram_port_responder.sv
// Block-RAM stand-in for one SDRAM client port: answers the toggle req/ack
// handshake with programmable latency, stall injection and read-fault injection.
module sdram_port_responder #(
    parameter int unsigned ADDRWIDTH      = 10,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned FAULT_INTERVAL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [15:0]          din,
    input  logic [1:0]           be,
    input  logic                 stall,
    input  logic [15:0]          fault_mask,
    output logic                 ack,
    output logic [15:0]          q,
    output logic                 busy,
    output logic                 protocol_err,
    output logic [31:0]          readcount,
    output logic [31:0]          writecount,
    output logic [31:0]          faultcount
);

    localparam int unsigned DEPTH = 1 << ADDRWIDTH;
    localparam int unsigned CW    = 4;
    localparam int unsigned PW    = (FAULT_INTERVAL > 1) ? $clog2(FAULT_INTERVAL) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, COMPLETE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   req_lvl_q, req_lvl_d;
    logic                   we_q, we_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [15:0]            din_q, din_d;
    logic [1:0]             be_q, be_d;
    logic [15:0]            q_q, q_d;
    logic                   busy_q, busy_d;
    logic                   perr_q, perr_d;
    logic [31:0]            rd_cnt_q, rd_cnt_d;
    logic [31:0]            wr_cnt_q, wr_cnt_d;
    logic [31:0]            flt_cnt_q, flt_cnt_d;
    logic [PW-1:0]          phase_q, phase_d;

    logic                   mem_rd_c;
    logic                   mem_wr_c;
    logic                   fault_due_c;
    logic [15:0]            ram_rdata;
    logic [15:0]            mem [DEPTH];

    // The read that brings the phase counter back to zero is the faulted one
    assign fault_due_c = (FAULT_INTERVAL != 0) && (phase_q == PW'(FAULT_INTERVAL - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        req_lvl_d = req_lvl_q;
        we_d      = we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        be_d      = be_q;
        q_d       = q_q;
        busy_d    = busy_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        flt_cnt_d = flt_cnt_q;
        phase_d   = phase_q;
        mem_rd_c  = 1'b0;
        mem_wr_c  = 1'b0;
        perr_d    = perr_q | (busy_q & (req != req_lvl_q));

        case (state_q)
            IDLE: begin
                if (req != ack_q) begin
                    we_d      = we;
                    addr_d    = addr;
                    din_d     = din;
                    be_d      = be;
                    req_lvl_d = req;
                    cnt_d     = CW'(LATENCY - 1);
                    busy_d    = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!stall) begin
                    if (cnt_q == CW'(0)) begin
                        // RAM read launched here so data is registered for COMPLETE
                        mem_rd_c = ~we_q;
                        state_d  = COMPLETE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            COMPLETE: begin
                ack_d   = req_lvl_q;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (we_q) begin
                    mem_wr_c = 1'b1;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                    q_d      = ram_rdata ^ (fault_due_c ? fault_mask : 16'h0000);
                    if (fault_due_c) begin
                        flt_cnt_d = flt_cnt_q + 32'd1;
                    end
                    if (FAULT_INTERVAL != 0) begin
                        phase_d = fault_due_c ? PW'(0) : phase_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            req_lvl_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            be_q      <= '0;
            q_q       <= '0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            flt_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            req_lvl_q <= req_lvl_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            be_q      <= be_d;
            q_q       <= q_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            flt_cnt_q <= flt_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Single-port RAM with byte-lane writes; contents are never reset
    always_ff @(posedge clk) begin
        if (mem_rd_c) begin
            ram_rdata <= mem[addr_q];
        end
        if (mem_wr_c) begin
            if (be_q[0]) mem[addr_q][7:0]  <= din_q[7:0];
            if (be_q[1]) mem[addr_q][15:8] <= din_q[15:8];
        end
    end

    assign ack          = ack_q;
    assign q            = q_q;
    assign busy         = busy_q;
    assign protocol_err = perr_q;
    assign readcount    = rd_cnt_q;
    assign writecount   = wr_cnt_q;
    assign faultcount   = flt_cnt_q;

endmodule

// File: tb/tb_sdram_port_responder.sv
// Scoreboard bench for sdram_port_responder: driver pushes model predictions,
// an independent monitor pops them on every ack toggle.
module tb_sdram_port_responder;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;
    localparam int unsigned FI  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    be;
    logic          stall;
    logic [15:0]   fault_mask;
    logic          ack;
    logic [15:0]   q;
    logic          busy;
    logic          protocol_err;
    logic [31:0]   readcount;
    logic [31:0]   writecount;
    logic [31:0]   faultcount;

    always #5 clk = ~clk;

    sdram_port_responder #(.ADDRWIDTH(AW), .LATENCY(LAT), .FAULT_INTERVAL(FI)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .din(din),
        .be(be), .stall(stall), .fault_mask(fault_mask), .ack(ack), .q(q),
        .busy(busy), .protocol_err(protocol_err), .readcount(readcount),
        .writecount(writecount), .faultcount(faultcount)
    );

    typedef struct {
        logic [15:0] q;
        bit          lvl;
        int          base;
        int          stalls;
        int unsigned rc;
        int unsigned wc;
        int unsigned fc;
        bit          perr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl_mem [32];
    int unsigned m_rc = 0, m_wc = 0, m_fc = 0;
    logic [15:0] m_q = 16'h0;
    bit          m_perr = 1'b0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sequential memory semantics, every FI-th read since reset faulted
    function automatic exp_t model_op(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                                      input logic [1:0] b, input logic [15:0] mask,
                                      input bit lvl, input int base, input int stalls);
        exp_t e;
        if (w) begin
            if (b[0]) mdl_mem[a][7:0]  = d[7:0];
            if (b[1]) mdl_mem[a][15:8] = d[15:8];
            m_wc++;
        end else begin
            m_rc++;
            if ((m_rc % FI) == 0) begin
                m_fc++;
                m_q = mdl_mem[a] ^ mask;
            end else begin
                m_q = mdl_mem[a];
            end
        end
        e.q = m_q; e.lvl = lvl; e.base = base; e.stalls = stalls;
        e.rc = m_rc; e.wc = m_wc; e.fc = m_fc; e.perr = m_perr;
        return e;
    endfunction

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ack_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                         input logic [1:0] b, input int stalls);
        @(negedge clk);
        we = w; addr = a; din = d; be = b;
        sb.push_back(model_op(w, a, d, b, fault_mask, ~req, cyc, stalls));
        req = ~req;
        @(negedge clk);
        // Inputs are latched at accept; scramble them to prove it
        we = 1'($urandom); addr = AW'($urandom); din = 16'($urandom); be = 2'($urandom);
        if (stalls > 0) begin
            stall = 1'b1;
            repeat (stalls) @(negedge clk);
            stall = 1'b0;
        end
        wait_done();
    endtask

    // Monitor: every ack toggle retires one scoreboard entry
    initial begin
        exp_t e;
        int   expc;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_ack = 1'b0;
                continue;
            end
            if (ack !== mon_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    expc = ((e.base < 0) ? last_ack_cyc : e.base) + LAT + 2 + e.stalls;
                    chk("ack_level", 32'(ack), 32'(e.lvl));
                    chk("ack_latency_cycle", cyc, expc);
                    chk("q", 32'(q), 32'(e.q));
                    chk("busy_after_ack", 32'(busy), 32'd0);
                    chk("readcount", readcount, e.rc);
                    chk("writecount", writecount, e.wc);
                    chk("faultcount", faultcount, e.fc);
                    chk("protocol_err", 32'(protocol_err), 32'(e.perr));
                end
                mon_ack = ack;
                last_ack_cyc = cyc;
            end
        end
    end

    initial begin
        bit lvl1;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; din = '0; be = '0;
        stall = 1'b0; fault_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(protocol_err), 0);
        chk("rst_counts", readcount | writecount | faultcount, 0);
        reset = 1'b0;

        // Fault injection first so read numbers match 1..9
        issue(1'b1, AW'(7), 16'h0000, 2'b11, 0);
        fault_mask = 16'h0100;
        for (int i = 0; i < 9; i++) issue(1'b0, AW'(7), 16'h0, 2'b00, 0);
        fault_mask = 16'h0000;

        for (int a = 0; a < 32; a++) issue(1'b1, AW'(a), 16'($urandom), 2'b11, 0);

        issue(1'b1, AW'(5'h12), 16'hA5C3, 2'b11, 0);
        issue(1'b0, AW'(5'h12), 16'h0, 2'b00, 0);

        issue(1'b1, AW'(5), 16'h1234, 2'b11, 0);
        issue(1'b1, AW'(5), 16'hABCD, 2'b10, 0);
        issue(1'b0, AW'(5), 16'h0, 2'b00, 0);
        issue(1'b1, AW'(5), 16'hFFFF, 2'b00, 0);
        issue(1'b0, AW'(5), 16'h0, 2'b00, 0);

        issue(1'b0, AW'(5'h12), 16'h0, 2'b00, 7);

        for (int i = 0; i < 150; i++) begin
            fault_mask = 16'($urandom);
            issue(1'(($urandom_range(0, 1))), AW'($urandom_range(0, 31)), 16'($urandom),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        // Second req toggle while busy: sticky error, both accesses serviced
        @(negedge clk);
        we = 1'b0; addr = AW'(5'h12); fault_mask = 16'h00F0;
        m_perr = 1'b1;
        lvl1 = ~req;
        sb.push_back(model_op(1'b0, AW'(5'h12), 16'h0, 2'b00, fault_mask, lvl1, cyc, 0));
        req = ~req;
        repeat (2) @(negedge clk);
        sb.push_back(model_op(1'b0, AW'(5'h12), 16'h0, 2'b00, fault_mask, ~lvl1, -1, 0));
        req = ~req;
        wait_done();

        for (int i = 0; i < 10; i++) begin
            fault_mask = 16'($urandom);
            issue(1'(($urandom_range(0, 1))), AW'($urandom_range(0, 31)), 16'($urandom),
                  2'($urandom_range(0, 3)), 0);
        end

        // Reset while a request sits in WAIT
        @(negedge clk);
        we = 1'b0; addr = AW'(3);
        req = ~req;
        repeat (2) @(negedge clk);
        chk("busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_ack", 32'(ack), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_counts", readcount | writecount | faultcount, 0);
        chk("async_rst_perr", 32'(protocol_err), 0);
        chk("async_rst_q", 32'(q), 0);
        sb.delete();
        m_rc = 0; m_wc = 0; m_fc = 0; m_q = 16'h0; m_perr = 1'b0;
        req = 1'b1;
        repeat (2) @(negedge clk);
        we = 1'b1; addr = AW'(3); din = 16'h5A5A; be = 2'b11; fault_mask = 16'h0000;
        sb.push_back(model_op(1'b1, AW'(3), 16'h5A5A, 2'b11, fault_mask, 1'b1, cyc, 0));
        reset = 1'b0;
        wait_done();
        issue(1'b0, AW'(3), 16'h0, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
